// File: rtl/axi_ram_slave.sv
// AXI4 slave RAM: serves one write or read burst at a time from a word-addressed
// synchronous RAM, alternating priority between simultaneous AW and AR requests.
module axi_ram_slave #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic                s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic                s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic                s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int AW    = ADDR_W - 2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               prio_w_q;
  logic               id_q;
  logic [AW-1:0]      addr_q;
  logic [7:0]         len_q;
  logic               fixed_q;
  logic               err_q;
  logic [8:0]         cnt_q;
  logic               bvalid_q, bid_q;
  logic [1:0]         bresp_q;
  logic               rvalid_q, rlast_q, rid_q;
  logic [1:0]         rresp_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               grant_w, grant_r;
  logic               w_hs, b_hs, r_hs, rd_issue;
  logic               last_beat, beats_left, w_bad;
  logic [AW-1:0]      addr_nxt;
  logic               unused_s;

  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || (burst == 2'b10);
  endfunction

  function automatic logic [1:0] resp_of(input logic err);
    return err ? 2'b10 : 2'b00;
  endfunction

  assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awaddr[1:0],
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_araddr[1:0]};

  // Arbitration, handshakes and beat bookkeeping
  always_comb begin
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      grant_w = s_axi_awvalid && (!s_axi_arvalid || prio_w_q);
      grant_r = s_axi_arvalid && (!s_axi_awvalid || !prio_w_q);
    end else begin
      grant_w = 1'b0;
      grant_r = 1'b0;
    end
    last_beat  = (cnt_q == {1'b0, len_q});
    beats_left = (cnt_q <= {1'b0, len_q});
    w_hs       = (state_q == WDATA) && s_axi_wvalid && !rst;
    w_bad      = (s_axi_wlast != last_beat);
    b_hs       = bvalid_q && s_axi_bready;
    r_hs       = rvalid_q && s_axi_rready;
    rd_issue   = (state_q == RDATA) && beats_left && (!rvalid_q || s_axi_rready);
    addr_nxt   = fixed_q ? addr_q : addr_q + {{(AW-1){1'b0}}, 1'b1};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d = WDATA;
        end else if (grant_r) begin
          state_d = RDATA;
        end else begin
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (w_hs && last_beat) begin
          state_d = WRESP;
        end else begin
          state_d = WDATA;
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_d = IDLE;
        end else begin
          state_d = WRESP;
        end
      end
      RDATA: begin
        if (r_hs && rlast_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context, write response and read output register
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_w_q <= 1'b1;
      id_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= 8'd0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 9'd0;
      bvalid_q <= 1'b0;
      bid_q    <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      if (grant_w || grant_r) begin
        prio_w_q <= ~prio_w_q;
        cnt_q    <= 9'd0;
        if (grant_w) begin
          id_q    <= s_axi_awid;
          addr_q  <= s_axi_awaddr[ADDR_W-1:2];
          len_q   <= s_axi_awlen;
          fixed_q <= (s_axi_awburst == 2'b00);
          err_q   <= req_err(s_axi_awsize, s_axi_awburst);
        end else begin
          id_q    <= s_axi_arid;
          addr_q  <= s_axi_araddr[ADDR_W-1:2];
          len_q   <= s_axi_arlen;
          fixed_q <= (s_axi_arburst == 2'b00);
          err_q   <= req_err(s_axi_arsize, s_axi_arburst);
        end
      end
      if (w_hs) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + 9'd1;
        if (w_bad) begin
          err_q <= 1'b1;
        end
      end
      // The response must include a wlast violation seen on the final beat itself
      if (w_hs && last_beat) begin
        bvalid_q <= 1'b1;
        bid_q    <= id_q;
        bresp_q  <= resp_of(err_q || w_bad);
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
        bid_q    <= 1'b0;
        bresp_q  <= 2'b00;
      end
      if (rd_issue) begin
        rdata_q  <= mem[addr_q];
        rvalid_q <= 1'b1;
        rlast_q  <= last_beat;
        rresp_q  <= resp_of(err_q);
        rid_q    <= id_q;
        addr_q   <= addr_nxt;
        cnt_q    <= cnt_q + 9'd1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (s_axi_wstrb[i]) begin
          mem[addr_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  assign s_axi_awready = grant_w;
  assign s_axi_arready = grant_r;
  assign s_axi_wready  = (state_q == WDATA);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: bursts, strobes, stalls, arbitration, errors, mid-burst reset.
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awid, awvalid, awready, awlock;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bid, bvalid, bready;
  logic [1:0]  bresp;
  logic        arid, arvalid, arready, arlock;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos;
  logic        rid, rlast, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] wvals   [0:15];
  logic [31:0] rd_data [0:15];
  logic        rd_last [0:15];
  logic [1:0]  rd_resp [0:15];
  logic        rd_id   [0:15];
  int          rcnt, first_g, last_g, waited;

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
    .s_axi_awqos(awqos), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot),
    .s_axi_arqos(arqos), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after posedge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic aw_send(input logic id, input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int w);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    w = 0;
    #1;
    while (!awready && w < 50) begin tick(); #1; w++; end
    chk("aw_grant", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int w);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    w = 0;
    #1;
    while (!arready && w < 50) begin tick(); #1; w++; end
    chk("ar_grant", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic w_send(input int n, input logic [3:0] strb, input int lastpos,
                        input logic [1:0] exp_resp, input logic exp_id);
    int g;
    for (int i = 0; i < n; i++) begin
      wdata = wvals[i]; wstrb = strb; wlast = (i == lastpos); wvalid = 1'b1;
      #1;
      g = 0;
      while (!wready && g < 50) begin tick(); #1; g++; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("bvalid_lat", 32'(bvalid), 32'd1);
    bready = 1'b1;
    g = 0;
    while (!bvalid && g < 50) begin tick(); #1; g++; end
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("bid", 32'(bid), 32'(exp_id));
    tick();
    bready = 1'b0;
  endtask

  task automatic r_collect(input int n, input bit stall);
    int          g;
    logic        stalled;
    logic [31:0] held;
    rcnt = 0; g = 0; stalled = 1'b0; held = 32'd0; first_g = -1; last_g = -1;
    while (rcnt < n && g < 500) begin
      rready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (stalled) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, held);
      end
      if (rvalid && rready) begin
        rd_data[rcnt] = rdata; rd_last[rcnt] = rlast; rd_resp[rcnt] = rresp; rd_id[rcnt] = rid;
        if (rcnt == 0) first_g = g;
        last_g = g;
        rcnt++;
      end
      stalled = rvalid && !rready;
      held = rdata;
      tick();
      g++;
    end
    rready = 1'b0;
    if (rcnt < n) chk("r_timeout", 32'(rcnt), 32'(n));
  endtask

  initial begin
    int          g, got;
    logic        gw;
    logic [31:0] exp_w;
    awlock = 1'b0; awcache = 4'd0; awprot = 3'd0; awqos = 4'd0;
    arlock = 1'b0; arcache = 4'd0; arprot = 3'd0; arqos = 4'd0;
    awid = 1'b0; awaddr = 16'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1;
    arid = 1'b0; araddr = 16'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0;
    do_reset();

    // Simultaneous AW and AR right after reset: W, R, W, R
    awaddr = 16'h0300; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1;
    araddr = 16'h0300; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
    awvalid = 1'b1; arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      #1;
      while (!(awready || arready) && g < 50) begin tick(); #1; g++; end
      chk("arb_excl", 32'(awready && arready), 32'd0);
      gw = awready;
      chk("arb_order", 32'(gw), 32'((k % 2) == 0));
      tick();
      if (gw) begin
        wdata = 32'hA0 + 32'(k); wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        g = 0;
        #1;
        while (!bvalid && g < 50) begin tick(); #1; g++; end
        tick();
        bready = 1'b0;
      end else begin
        rready = 1'b1;
        g = 0;
        #1;
        while (!rvalid && g < 50) begin tick(); #1; g++; end
        chk("arb_rdata", rdata, 32'hA0 + 32'(k - 1));
        tick();
        rready = 1'b0;
      end
    end
    awvalid = 1'b0; arvalid = 1'b0;
    tick();

    // Single write then read with id 1
    wvals[0] = 32'hDEADBEEF;
    aw_send(1'b1, 16'h0010, 8'd0, 3'd2, 2'd1, waited);
    w_send(1, 4'hF, 0, 2'b00, 1'b1);
    ar_send(1'b1, 16'h0010, 8'd0, 3'd2, 2'd1, waited);
    r_collect(1, 1'b0);
    chk("single_data", rd_data[0], 32'hDEADBEEF);
    chk("single_last", 32'(rd_last[0]), 32'd1);
    chk("single_rid", 32'(rd_id[0]), 32'd1);
    chk("single_lat", 32'(first_g), 32'd1);

    // 16-beat INCR write/read of 0..15 at 0x100
    for (int i = 0; i < 16; i++) wvals[i] = 32'(i);
    aw_send(1'b0, 16'h0100, 8'd15, 3'd2, 2'd1, waited);
    w_send(16, 4'hF, 15, 2'b00, 1'b0);
    ar_send(1'b0, 16'h0100, 8'd15, 3'd2, 2'd1, waited);
    r_collect(16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("b16_data", rd_data[i], 32'(i));
      chk("b16_last", 32'(rd_last[i]), 32'(i == 15));
      chk("b16_resp", 32'(rd_resp[i]), 32'd0);
    end
    chk("b16_first", 32'(first_g), 32'd1);
    chk("b16_back2back", 32'(last_g - first_g), 32'd15);

    // Partial strobes at 0x40
    wvals[0] = 32'h11223344;
    aw_send(1'b0, 16'h0040, 8'd0, 3'd2, 2'd1, waited);
    w_send(1, 4'hF, 0, 2'b00, 1'b0);
    wvals[0] = 32'hAABBCCDD;
    aw_send(1'b0, 16'h0040, 8'd0, 3'd2, 2'd1, waited);
    w_send(1, 4'h5, 0, 2'b00, 1'b0);
    ar_send(1'b0, 16'h0040, 8'd0, 3'd2, 2'd1, waited);
    r_collect(1, 1'b0);
    chk("strb_data", rd_data[0], 32'h11BB33DD);

    // 8-beat read with random rready stalls
    ar_send(1'b0, 16'h0100, 8'd7, 3'd2, 2'd1, waited);
    r_collect(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("stall_data", rd_data[i], 32'(i));
      chk("stall_last", 32'(rd_last[i]), 32'(i == 7));
    end

    // FIXED burst repeats one word
    ar_send(1'b0, 16'h0104, 8'd2, 3'd2, 2'd0, waited);
    r_collect(3, 1'b0);
    for (int i = 0; i < 3; i++) chk("fixed_data", rd_data[i], 32'd1);

    // wlast on beat 1 of a 4-beat write: SLVERR, data still written
    for (int i = 0; i < 4; i++) wvals[i] = 32'h5000 + 32'(i);
    aw_send(1'b0, 16'h0200, 8'd3, 3'd2, 2'd1, waited);
    w_send(4, 4'hF, 1, 2'b10, 1'b0);
    ar_send(1'b0, 16'h020C, 8'd0, 3'd2, 2'd1, waited);
    r_collect(1, 1'b0);
    chk("werr_kept", rd_data[0], 32'h5003);

    // Read with size 1: every beat SLVERR, data still returned
    ar_send(1'b0, 16'h0100, 8'd1, 3'd1, 2'd1, waited);
    r_collect(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("rerr_resp", 32'(rd_resp[i]), 32'd2);
      chk("rerr_data", rd_data[i], 32'(i));
    end

    // Reset during beat 3 of an 8-beat read
    ar_send(1'b0, 16'h0100, 8'd7, 3'd2, 2'd1, waited);
    rready = 1'b1; got = 0; g = 0;
    while (got < 3 && g < 50) begin
      #1;
      if (rvalid) got++;
      tick();
      g++;
    end
    chk("mid_beats", 32'(got), 32'd3);
    rst = 1'b1;
    tick();
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    rst = 1'b0; rready = 1'b0;
    tick();
    ar_send(1'b0, 16'h0104, 8'd0, 3'd2, 2'd1, waited);
    chk("mid_idle", 32'(waited), 32'd0);
    r_collect(1, 1'b0);
    exp_w = 32'd1;
    chk("mid_ram_kept", rd_data[0], exp_w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
